// File: rtl/cfg_chain_readback_pkg.sv
// rtl/cfg_chain_readback_pkg.sv - shared types and defaults for the config chain loader and reader
package cfg_chain_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_FIN
  } chain_state_e;

endpackage

// File: rtl/cfg_chain_readback_if.sv
// rtl/cfg_chain_readback_if.sv - readback word stream between the chain reader and the compare logic
import cfg_chain_pkg::*;

interface cfg_chain_readback_if #(
  parameter int WORD_W = WORD_W_DEF
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              word_last;

  modport master (output word_data, word_valid, word_last, input word_ready);
  modport slave  (input word_data, word_valid, word_last, output word_ready);
endinterface

// File: rtl/cfg_shift_deser.sv
// rtl/cfg_shift_deser.sv - word-wide deserialiser; first captured bit lands in bit 0
import cfg_chain_pkg::*;

module cfg_shift_deser #(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_en_i,
  input  logic              clr_i,
  input  logic              ser_i,
  output logic [WORD_W-1:0] par_o
);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_q;

  // Clear wins over capture so a new word always starts from an all-zero register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (clr_i) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (cap_en_i) begin
      data_q[idx_q] <= ser_i;
      idx_q         <= idx_q + 1'b1;
    end
  end

  assign par_o = data_q;
endmodule

// File: rtl/cfg_chain_readback.sv
// rtl/cfg_chain_readback.sv - shifts the config chain tail out and packs it into a word stream
import cfg_chain_pkg::*;

module cfg_chain_readback #(
  parameter int WORD_W = WORD_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      chain_len_i,
  output logic                  shift_en_o,
  input  logic                  chain_tail_i,
  output logic                  busy_o,
  output logic                  done_o,
  cfg_chain_readback_if.master  word_if
);
  chain_state_e     state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rcvd_q;
  logic [LEN_W-1:0] rcvd_d;
  logic             shift_en_q;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;
  logic             cap_en;
  logic             clr;
  logic             word_full;
  logic             chain_end;

  assign rcvd_d    = rcvd_q + 1'b1;
  assign word_full = (rcvd_d % LEN_W'(WORD_W)) == '0;
  assign chain_end = (rcvd_d == len_q);

  assign cap_en = (state_q == ST_SHIFT);
  assign clr    = ((state_q == ST_IDLE) && start_i) ||
                  ((state_q == ST_HOLD) && word_if.word_ready && !last_q);

  cfg_shift_deser #(.WORD_W(WORD_W)) u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_en_i (cap_en),
    .clr_i    (clr),
    .ser_i    (chain_tail_i),
    .par_o    (word_if.word_data)
  );

  // Count is compared against len_q before it increments, so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      rcvd_q     <= '0;
      shift_en_q <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            len_q  <= chain_len_i;
            rcvd_q <= '0;
            busy_q <= 1'b1;
            if (chain_len_i != '0) begin
              state_q    <= ST_SHIFT;
              shift_en_q <= 1'b1;
            end else begin
              state_q <= ST_FIN;
            end
          end
        end
        ST_SHIFT: begin
          rcvd_q <= rcvd_d;
          if (word_full || chain_end) begin
            state_q    <= ST_HOLD;
            shift_en_q <= 1'b0;
            valid_q    <= 1'b1;
            last_q     <= chain_end;
          end
        end
        ST_HOLD: begin
          if (word_if.word_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (last_q) begin
              state_q <= ST_FIN;
            end else begin
              state_q    <= ST_SHIFT;
              shift_en_q <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign shift_en_o         = shift_en_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign word_if.word_valid = valid_q;
  assign word_if.word_last  = last_q;
endmodule

// File: tb/tb_cfg_chain_readback.sv
// tb/tb_cfg_chain_readback.sv - self-checking bench for cfg_chain_readback
module tb_cfg_chain_readback;
  import cfg_chain_pkg::*;

  localparam int WW = WORD_W_DEF;
  localparam int LW = LEN_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [LW-1:0] chain_len_i = '0;
  logic          shift_en_o;
  logic          chain_tail_i;
  logic          busy_o;
  logic          done_o;

  cfg_chain_readback_if #(.WORD_W(WW)) wif ();

  cfg_chain_readback #(.WORD_W(WW), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .chain_len_i  (chain_len_i),
    .shift_en_o   (shift_en_o),
    .chain_tail_i (chain_tail_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .word_if      (wif)
  );

  always #5 clk = ~clk;

  // Chain model: the tail shows bit pos; the chain advances after every edge seen with shift_en high.
  logic        chain_bits [0:4095];
  logic [11:0] pos = '0;
  logic        adv_pending = 1'b0;
  assign chain_tail_i = chain_bits[pos];

  int cyc = 0;
  int shift_cnt = 0, done_cnt = 0, overlap = 0;
  int start_cyc = 0, first_valid_cyc = -1, done_cyc = -1;
  logic [WW-1:0] got_data [$];
  logic          got_last [$];

  int passed = 0, total = 0, failed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (adv_pending && rst_n) pos = pos + 1'b1;
  end

  always @(negedge clk) begin
    if (wif.word_valid && wif.word_ready) begin
      got_data.push_back(wif.word_data);
      got_last.push_back(wif.word_last);
    end
    if (wif.word_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (shift_en_o) shift_cnt++;
    if (shift_en_o && wif.word_valid) overlap++;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    adv_pending = shift_en_o;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int idx, input logic [7:0] w);
    for (int b = 0; b < 8; b++) chain_bits[idx*8 + b] = w[b];
  endtask

  task automatic load_random(input int len);
    for (int i = 0; i < len; i++) chain_bits[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_start(input int len);
    @(posedge clk);
    #1;
    pos = '0;
    shift_cnt = 0; done_cnt = 0; overlap = 0;
    first_valid_cyc = -1; done_cyc = -1;
    got_data.delete();
    got_last.delete();
    chain_len_i = LW'(len);
    start_i = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int stall_max, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      wif.word_ready = (stall_max == 0) ? 1'b1 : ($urandom_range(0, stall_max) == 0);
      #5;
      if (done_cnt > 0) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    repeat (3) @(posedge clk);
    #6;
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_busy_low"}, busy_o, 0);
  endtask

  // Reference: word i holds chain bits i*WW .. i*WW+WW-1, missing bits read as zero.
  task automatic verify(input int len, input string tag);
    int nw = (len + WW - 1) / WW;
    logic [WW-1:0] exp_w;
    check({tag, "_nwords"}, got_data.size(), nw);
    for (int i = 0; i < nw && i < got_data.size(); i++) begin
      exp_w = '0;
      for (int b = 0; b < WW; b++)
        if (i*WW + b < len) exp_w[b] = chain_bits[i*WW + b];
      check($sformatf("%s_word%0d", tag, i), got_data[i], exp_w);
      check($sformatf("%s_last%0d", tag, i), got_last[i], (i == nw - 1));
    end
    check({tag, "_shift_cycles"}, shift_cnt, len);
    check({tag, "_no_overlap"}, overlap, 0);
    if (len > 0)
      check({tag, "_latency"}, first_valid_cyc - (start_cyc + 1), (len < WW) ? len : WW);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_shift_en"}, shift_en_o, 0);
    check({tag, "_valid"}, wif.word_valid, 0);
    check({tag, "_last"}, wif.word_last, 0);
    check({tag, "_data"}, wif.word_data, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    logic [WW-1:0] held;
    bit got_valid;
    wif.word_ready = 1'b0;
    for (int i = 0; i < 4096; i++) chain_bits[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Two full words, ready always high.
    load_word(0, 8'hA5);
    load_word(1, 8'h3C);
    do_start(16);
    wait_done(200, 0, "len16");
    verify(16, "len16");

    // Partial final word.
    for (int i = 0; i < 11; i++) chain_bits[i] = 1'b1;
    do_start(11);
    wait_done(200, 0, "len11");
    verify(11, "len11");
    if (got_data.size() == 2) check("len11_partial_value", got_data[1], 8'h07);

    // Backpressure in HOLD for 5 cycles.
    wif.word_ready = 1'b0;
    load_random(8);
    do_start(8);
    got_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (wif.word_valid) begin
        got_valid = 1'b1;
        break;
      end
    end
    check("hold_valid_seen", got_valid, 1);
    held = wif.word_data;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #6;
      check($sformatf("hold_shift_off%0d", k), shift_en_o, 0);
      check($sformatf("hold_data_stable%0d", k), wif.word_data, held);
    end
    wait_done(200, 0, "hold");
    verify(8, "hold");

    // Zero-length readback.
    do_start(0);
    wait_done(50, 0, "len0");
    verify(0, "len0");
    check("len0_no_valid", first_valid_cyc, -1);
    check("len0_done_delay", done_cyc - start_cyc, 2);

    // Start re-pulsed while busy must be ignored.
    load_random(16);
    do_start(16);
    repeat (3) @(posedge clk);
    #1;
    chain_len_i = LW'(3);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(200, 0, "repulse");
    verify(16, "repulse");

    // Asynchronous reset in the middle of SHIFT.
    load_random(16);
    do_start(16);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (shift_cnt >= 5) break;
    end
    check("rst_mid_bits", shift_cnt, 5);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_done", done_cnt, 0);
    load_random(8);
    do_start(8);
    wait_done(200, 0, "post_rst");
    verify(8, "post_rst");

    // Randomized lengths and consumer stalls.
    for (int t = 0; t < 8; t++) begin
      int len = $urandom_range(1, 40);
      int stall = $urandom_range(0, 3);
      load_random(len);
      do_start(len);
      wait_done(len * 8 + 200, stall, $sformatf("rand%0d", t));
      verify(len, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
